trigger_arm_ctrl: RTL and testbench

//  Run-controller for the trigger generator. Drives its trig_enable and watches detect_pls_0/1.

---
 rtl/trig_ctrl_pkg.sv | 20 ++
 rtl/trigger_arm_ctrl_if.sv | 51 +++++
 rtl/trig_ctrl_timer.sv | 21 ++
 rtl/trigger_arm_ctrl.sv | 123 ++++++++++++
 tb/tb_trigger_arm_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trig_ctrl_pkg.sv
// Shared definitions for the trigger run-controller and its status register block.
// State encodings and status-register bit positions.
package trig_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_WAIT_P1 = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_HOLDOFF = 3'd4
   } state_t;

   // Status register layout shared with the AXI register block
   localparam int STAT_BUSY_BIT  = 0;
   localparam int STAT_IRQ_BIT   = 1;
   localparam int STAT_TOFV_BIT  = 2;
   localparam int STAT_STATE_LSB = 4;
   localparam int STAT_STATE_MSB = 6;

endpackage

// File: rtl/trigger_arm_ctrl_if.sv
// Config/status and trigger-generator signals of trigger_arm_ctrl.
// ts_capt exists only when TRIG_ARM_TIMESTAMP_EN is defined.
interface trigger_arm_ctrl_if #(
   parameter int CNT_WIDTH  = 32,
   parameter int SHOT_WIDTH = 16
) ();

   logic                  cfg_arm;
   logic                  cfg_abort;
   logic                  cfg_auto_rearm;
   logic [SHOT_WIDTH-1:0] cfg_shots;
   logic [CNT_WIDTH-1:0]  cfg_timeout;
   logic [CNT_WIDTH-1:0]  cfg_holdoff;
   logic                  detect_pls_0;
   logic                  detect_pls_1;
   logic [CNT_WIDTH-1:0]  pulse_tof;
   logic                  trig_enable;
   logic [CNT_WIDTH-1:0]  tof_capt;
   logic                  tof_valid;
   logic [SHOT_WIDTH-1:0] shot_cnt;
   logic [SHOT_WIDTH-1:0] timeout_cnt;
   logic                  busy;
   logic [2:0]            state_o;
   logic                  irq;
`ifdef TRIG_ARM_TIMESTAMP_EN
   logic [63:0]           ts_capt;

   modport master (
      output cfg_arm, cfg_abort, cfg_auto_rearm, cfg_shots, cfg_timeout, cfg_holdoff,
             detect_pls_0, detect_pls_1, pulse_tof,
      input  trig_enable, tof_capt, tof_valid, shot_cnt, timeout_cnt, busy, state_o, irq, ts_capt
   );
   modport slave (
      input  cfg_arm, cfg_abort, cfg_auto_rearm, cfg_shots, cfg_timeout, cfg_holdoff,
             detect_pls_0, detect_pls_1, pulse_tof,
      output trig_enable, tof_capt, tof_valid, shot_cnt, timeout_cnt, busy, state_o, irq, ts_capt
   );
`else
   modport master (
      output cfg_arm, cfg_abort, cfg_auto_rearm, cfg_shots, cfg_timeout, cfg_holdoff,
             detect_pls_0, detect_pls_1, pulse_tof,
      input  trig_enable, tof_capt, tof_valid, shot_cnt, timeout_cnt, busy, state_o, irq
   );
   modport slave (
      input  cfg_arm, cfg_abort, cfg_auto_rearm, cfg_shots, cfg_timeout, cfg_holdoff,
             detect_pls_0, detect_pls_1, pulse_tof,
      output trig_enable, tof_capt, tof_valid, shot_cnt, timeout_cnt, busy, state_o, irq
   );
`endif

endinterface

// File: rtl/trig_ctrl_timer.sv
// Clearable up-counter that stops at its compare value; done while count == limit.
module trig_ctrl_timer #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic [W-1:0] limit,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr)        cnt <= '0;
      else if (cnt != limit) cnt <= cnt + W'(1);
   end

   assign done = (cnt == limit);

endmodule

// File: rtl/trigger_arm_ctrl.sv
// Run-controller for the trigger generator: arm, capture TOF per shot, timeout, holdoff, re-arm.
// Optional TRIG_ARM_TIMESTAMP_EN adds a 64-bit timestamp of the pulse-0 edge (ts_capt).
module trigger_arm_ctrl
   import trig_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH  = 32,
   parameter int SHOT_WIDTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   trigger_arm_ctrl_if.slave bus
);

   state_t                state_q, state_d;
   logic                  sh_auto;
   logic [SHOT_WIDTH-1:0] sh_shots;
   logic [CNT_WIDTH-1:0]  sh_timeout, sh_holdoff, ho_limit;
   logic                  p0_q, p1_q, rise0, rise1;
   logic                  to_done, ho_done, to_hit, rearm, arm_acc;
   logic                  trig_en, busy_c, do_capture, do_timeout, run_end, tof_load;
   logic [CNT_WIDTH-1:0]  tof_hold, tof_q;
   logic                  tof_v_q, irq_q;
   logic [SHOT_WIDTH-1:0] shot_q, tmo_q;

   assign rise0   = bus.detect_pls_0 & ~p0_q;
   assign rise1   = bus.detect_pls_1 & ~p1_q;
   assign arm_acc = (state_q == ST_IDLE) && bus.cfg_arm && !bus.cfg_abort;
   assign to_hit  = (sh_timeout != '0) && to_done;
   assign rearm   = sh_auto && ((sh_shots == '0) || (shot_q < sh_shots));
   // Holdoff of 0 behaves as 1; the timer counts from 0 so the compare value is holdoff-1
   assign ho_limit = (sh_holdoff == '0) ? '0 : sh_holdoff - CNT_WIDTH'(1);

   trig_ctrl_timer #(.W(CNT_WIDTH)) u_timeout (
      .clk(clk), .rst(rst), .clr(state_q != ST_WAIT_P1), .limit(sh_timeout), .done(to_done)
   );
   trig_ctrl_timer #(.W(CNT_WIDTH)) u_holdoff (
      .clk(clk), .rst(rst), .clr(state_q != ST_HOLDOFF), .limit(ho_limit), .done(ho_done)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (arm_acc) state_d = ST_ARMED;
         ST_ARMED:   if (rise1) state_d = ST_CAPTURE;
                     else if (rise0) state_d = ST_WAIT_P1;
         ST_WAIT_P1: if (rise1) state_d = ST_CAPTURE;
                     else if (to_hit) state_d = ST_HOLDOFF;
         ST_CAPTURE: state_d = ST_HOLDOFF;
         ST_HOLDOFF: if (ho_done) state_d = rearm ? ST_ARMED : ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
      if (bus.cfg_abort) state_d = ST_IDLE;
   end

   always_comb begin
      trig_en    = (state_q == ST_ARMED) || (state_q == ST_WAIT_P1) || (state_q == ST_CAPTURE);
      busy_c     = (state_q != ST_IDLE);
      tof_load   = rise1 && ((state_q == ST_ARMED) || (state_q == ST_WAIT_P1));
      do_capture = (state_q == ST_CAPTURE) && !bus.cfg_abort;
      do_timeout = (state_q == ST_WAIT_P1) && !rise1 && to_hit && !bus.cfg_abort;
      run_end    = bus.cfg_abort || ((state_q == ST_HOLDOFF) && ho_done && !rearm);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p0_q <= 1'b0;  p1_q <= 1'b0;
         sh_auto <= 1'b0;  sh_shots <= '0;  sh_timeout <= '0;  sh_holdoff <= '0;
         tof_hold <= '0;  tof_q <= '0;  tof_v_q <= 1'b0;
         shot_q <= '0;  tmo_q <= '0;  irq_q <= 1'b0;
      end else begin
         // Edge history is dropped while the generator is held off so a level re-triggers
         p0_q <= (state_q == ST_IDLE || state_q == ST_HOLDOFF) ? 1'b0 : bus.detect_pls_0;
         p1_q <= (state_q == ST_IDLE || state_q == ST_HOLDOFF) ? 1'b0 : bus.detect_pls_1;
         if (arm_acc) begin
            sh_auto    <= bus.cfg_auto_rearm;
            sh_shots   <= bus.cfg_shots;
            sh_timeout <= bus.cfg_timeout;
            sh_holdoff <= bus.cfg_holdoff;
            shot_q     <= '0;
            tmo_q      <= '0;
         end
         if (tof_load) tof_hold <= bus.pulse_tof;
         tof_v_q <= do_capture;
         if (do_capture) begin
            tof_q <= tof_hold;
            if (shot_q != '1) shot_q <= shot_q + SHOT_WIDTH'(1);
         end
         if (do_timeout && tmo_q != '1) tmo_q <= tmo_q + SHOT_WIDTH'(1);
         irq_q <= run_end;
      end
   end

`ifdef TRIG_ARM_TIMESTAMP_EN
   logic [63:0] ts_cnt, ts_rise0, ts_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ts_cnt <= '0;  ts_rise0 <= '0;  ts_q <= '0;
      end else begin
         ts_cnt <= ts_cnt + 64'd1;
         if (rise0 && state_q == ST_ARMED) ts_rise0 <= ts_cnt;
         if (do_capture) ts_q <= ts_rise0;
      end
   end

   assign bus.ts_capt = ts_q;
`endif

   assign bus.trig_enable = trig_en;
   assign bus.busy        = busy_c;
   assign bus.state_o     = state_q;
   assign bus.tof_capt    = tof_q;
   assign bus.tof_valid   = tof_v_q;
   assign bus.shot_cnt    = shot_q;
   assign bus.timeout_cnt = tmo_q;
   assign bus.irq         = irq_q;

endmodule

// File: tb/tb_trigger_arm_ctrl.sv
// Scoreboard bench for trigger_arm_ctrl: expected TOF (and timestamp) queued at pulse-1 drive,
// compared when tof_valid strobes; scenario tasks check state, counters, holdoff and irq inline.
module tb_trigger_arm_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   typedef struct {
      logic [31:0] tof;
      logic [63:0] ts;
   } exp_t;
   exp_t sb[$];

   logic [63:0] ts_model;

   trigger_arm_ctrl_if #(.CNT_WIDTH(32), .SHOT_WIDTH(16)) bus ();
   trigger_arm_ctrl #(.CNT_WIDTH(32), .SHOT_WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) ts_model <= '0;
      else     ts_model <= ts_model + 64'd1;
   end

   // Scoreboard consumer
   always @(negedge clk) begin
      if (!rst && bus.tof_valid === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_tof_valid: got tof_capt=%h, want no strobe", bus.tof_capt);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (bus.tof_capt !== e.tof) begin
               errors++;
               $display("FAIL tof_capt: got %h want %h", bus.tof_capt, e.tof);
            end
`ifdef TRIG_ARM_TIMESTAMP_EN
            checks++;
            if (bus.ts_capt !== e.ts) begin
               errors++;
               $display("FAIL ts_capt: got %0d want %0d", bus.ts_capt, e.ts);
            end
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish within 200000 ns, want finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic arm(input logic auto_r, input logic [15:0] shots,
                      input logic [31:0] tmo, input logic [31:0] ho);
      bus.cfg_auto_rearm = auto_r;
      bus.cfg_shots      = shots;
      bus.cfg_timeout    = tmo;
      bus.cfg_holdoff    = ho;
      bus.cfg_arm        = 1'b1;
      tick();
      bus.cfg_arm        = 1'b0;
   endtask

   task automatic pulse0(output logic [63:0] ts);
      bus.detect_pls_0 = 1'b1;
      ts = ts_model;
      tick();
      bus.detect_pls_0 = 1'b0;
   endtask

   // pls1 held through the capture cycle; returns on the tof_valid cycle
   task automatic shoot(input logic [31:0] tof, input logic [63:0] ts);
      bus.detect_pls_1 = 1'b1;
      bus.pulse_tof    = tof;
      sb.push_back('{tof: tof, ts: ts});
      tick();
      tick();
      bus.detect_pls_1 = 1'b0;
      bus.pulse_tof    = 32'hDEAD_0000;
   endtask

   // counts consecutive cycles with enable low during a run
   task automatic wait_holdoff(output int n);
      n = 0;
      while (bus.trig_enable === 1'b0 && bus.busy === 1'b1 && n < 1000) begin
         n++;
         tick();
      end
   endtask

   task automatic test_reset();
      logic [87:0] outs;
      rst = 1'b1;
      repeat (3) tick();
      outs = {bus.trig_enable, bus.tof_valid, bus.busy, bus.irq, bus.state_o,
              bus.shot_cnt, bus.timeout_cnt, bus.tof_capt};
      checks++;
      if (outs !== '0) begin errors++; $display("FAIL reset_outs: got %h want 0", outs); end
      rst = 1'b0;
      tick();
      checks++;
      if (bus.state_o !== 3'd0 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL reset_idle: got state=%0d busy=%b want 0 0", bus.state_o, bus.busy);
      end
   endtask

   task automatic test_single_shot();
      logic [63:0] ts;
      int n;
      arm(1'b0, 16'd0, 32'd0, 32'd4);
      checks++;
      if (bus.state_o !== 3'd1 || bus.trig_enable !== 1'b1) begin
         errors++; $display("FAIL armed: got state=%0d en=%b want 1 1", bus.state_o, bus.trig_enable);
      end
      pulse0(ts);
      checks++;
      if (bus.state_o !== 3'd2) begin errors++; $display("FAIL wait_p1: got %0d want 2", bus.state_o); end
      repeat (39) tick();
      bus.detect_pls_1 = 1'b1;
      bus.pulse_tof    = 32'h1234;
      sb.push_back('{tof: 32'h1234, ts: ts});
      tick();
      checks++;
      if (bus.tof_valid !== 1'b0 || bus.state_o !== 3'd3) begin
         errors++; $display("FAIL latency_early: got valid=%b state=%0d want 0 3", bus.tof_valid, bus.state_o);
      end
      tick();
      checks++;
      if (bus.tof_valid !== 1'b1) begin errors++; $display("FAIL latency: got valid=%b want 1", bus.tof_valid); end
      checks++;
      if (bus.shot_cnt !== 16'd1) begin errors++; $display("FAIL single_shot_cnt: got %0d want 1", bus.shot_cnt); end
      bus.detect_pls_1 = 1'b0;
      wait_holdoff(n);
      checks++;
      if (n != 4) begin errors++; $display("FAIL single_holdoff: got %0d want 4", n); end
      checks++;
      if (bus.irq !== 1'b1 || bus.state_o !== 3'd0) begin
         errors++; $display("FAIL single_end: got irq=%b state=%0d want 1 0", bus.irq, bus.state_o);
      end
      tick();
      checks++;
      if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_pulse: got %b want 0", bus.irq); end
   endtask

   task automatic test_auto_rearm();
      logic [63:0] ts;
      int n;
      arm(1'b1, 16'd3, 32'd0, 32'd5);
      for (int i = 0; i < 3; i++) begin
         pulse0(ts);
         repeat (3) tick();
         shoot(32'h100 + i, ts);
         wait_holdoff(n);
         checks++;
         if (n != 5) begin errors++; $display("FAIL rearm_holdoff%0d: got %0d want 5", i, n); end
         checks++;
         if (i < 2) begin
            if (bus.state_o !== 3'd1 || bus.irq !== 1'b0) begin
               errors++; $display("FAIL rearm_armed%0d: got state=%0d irq=%b want 1 0", i, bus.state_o, bus.irq);
            end
         end else if (bus.state_o !== 3'd0 || bus.irq !== 1'b1 || bus.busy !== 1'b0 || bus.shot_cnt !== 16'd3) begin
            errors++;
            $display("FAIL rearm_done: got state=%0d irq=%b busy=%b shots=%0d want 0 1 0 3",
                     bus.state_o, bus.irq, bus.busy, bus.shot_cnt);
         end
      end
      tick();
   endtask

   task automatic test_timeout();
      logic [63:0] ts;
      int n;
      arm(1'b0, 16'd0, 32'd100, 32'd1);
      pulse0(ts);
      repeat (100) tick();
      checks++;
      if (bus.state_o !== 3'd2) begin errors++; $display("FAIL tmo_before: got %0d want 2", bus.state_o); end
      tick();
      checks++;
      if (bus.state_o !== 3'd4 || bus.timeout_cnt !== 16'd1) begin
         errors++; $display("FAIL tmo_hit: got state=%0d tmo=%0d want 4 1", bus.state_o, bus.timeout_cnt);
      end
      wait_holdoff(n);
      checks++;
      if (n != 1 || bus.irq !== 1'b1 || bus.state_o !== 3'd0 || bus.shot_cnt !== 16'd0) begin
         errors++;
         $display("FAIL tmo_end: got ho=%0d irq=%b state=%0d shots=%0d want 1 1 0 0", n, bus.irq, bus.state_o, bus.shot_cnt);
      end
      tick();
      // pulse 1 lands in the same cycle the timer reaches the limit
      arm(1'b0, 16'd0, 32'd100, 32'd1);
      pulse0(ts);
      repeat (100) tick();
      bus.detect_pls_1 = 1'b1;
      bus.pulse_tof    = 32'hBEEF;
      sb.push_back('{tof: 32'hBEEF, ts: ts});
      tick();
      checks++;
      if (bus.state_o !== 3'd3 || bus.timeout_cnt !== 16'd0) begin
         errors++; $display("FAIL tmo_race: got state=%0d tmo=%0d want 3 0", bus.state_o, bus.timeout_cnt);
      end
      tick();
      bus.detect_pls_1 = 1'b0;
      checks++;
      if (bus.shot_cnt !== 16'd1) begin errors++; $display("FAIL tmo_race_shot: got %0d want 1", bus.shot_cnt); end
      wait_holdoff(n);
      tick();
   endtask

   task automatic test_abort();
      logic [63:0] ts;
      int n;
      arm(1'b1, 16'd0, 32'd0, 32'd2);
      pulse0(ts);
      tick();
      shoot(32'h55, ts);
      wait_holdoff(n);
      pulse0(ts);
      tick();
      bus.detect_pls_1 = 1'b1;
      bus.pulse_tof    = 32'h66;
      bus.cfg_abort    = 1'b1;
      tick();
      checks++;
      if (bus.state_o !== 3'd0 || bus.irq !== 1'b1 || bus.trig_enable !== 1'b0 || bus.shot_cnt !== 16'd1) begin
         errors++;
         $display("FAIL abort: got state=%0d irq=%b en=%b shots=%0d want 0 1 0 1",
                  bus.state_o, bus.irq, bus.trig_enable, bus.shot_cnt);
      end
      bus.detect_pls_1 = 1'b0;
      bus.cfg_abort    = 1'b0;
      repeat (3) tick();
      bus.cfg_arm   = 1'b1;
      bus.cfg_abort = 1'b1;
      tick();
      bus.cfg_arm   = 1'b0;
      bus.cfg_abort = 1'b0;
      checks++;
      if (bus.state_o !== 3'd0 || bus.irq !== 1'b1) begin
         errors++; $display("FAIL arm_abort: got state=%0d irq=%b want 0 1", bus.state_o, bus.irq);
      end
      tick();
   endtask

   task automatic test_rst_mid();
      logic [63:0] ts;
      logic [87:0] outs;
      arm(1'b0, 16'd0, 32'd0, 32'd1);
      pulse0(ts);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      outs = {bus.trig_enable, bus.tof_valid, bus.busy, bus.irq, bus.state_o,
              bus.shot_cnt, bus.timeout_cnt, bus.tof_capt};
      checks++;
      if (outs !== '0) begin errors++; $display("FAIL rst_mid: got %h want 0", outs); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_arm_busy();
      logic [63:0] ts;
      int n;
      arm(1'b1, 16'd0, 32'd0, 32'd2);
      pulse0(ts);
      tick();
      shoot(32'h77, ts);
      wait_holdoff(n);
      arm(1'b0, 16'd5, 32'd0, 32'd9);
      checks++;
      if (bus.state_o !== 3'd1 || bus.shot_cnt !== 16'd1) begin
         errors++; $display("FAIL arm_ignored: got state=%0d shots=%0d want 1 1", bus.state_o, bus.shot_cnt);
      end
      pulse0(ts);
      tick();
      shoot(32'h78, ts);
      wait_holdoff(n);
      checks++;
      if (n != 2 || bus.state_o !== 3'd1 || bus.shot_cnt !== 16'd2) begin
         errors++;
         $display("FAIL shadow_cfg: got ho=%0d state=%0d shots=%0d want 2 1 2", n, bus.state_o, bus.shot_cnt);
      end
      bus.cfg_abort = 1'b1;
      tick();
      bus.cfg_abort = 1'b0;
      tick();
   endtask

   initial begin
      bus.cfg_arm = 1'b0;  bus.cfg_abort = 1'b0;  bus.cfg_auto_rearm = 1'b0;
      bus.cfg_shots = '0;  bus.cfg_timeout = '0;  bus.cfg_holdoff = '0;
      bus.detect_pls_0 = 1'b0;  bus.detect_pls_1 = 1'b0;  bus.pulse_tof = '0;
      test_reset();
      test_single_shot();
      test_auto_rearm();
      test_timeout();
      test_abort();
      test_rst_mid();
      test_arm_busy();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending want 0", sb.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
